// File: rtl/fibonacci_multi_lane.sv
// Generalised Fibonacci source: f(k+2) = f(k) + f(k+1) from two seeds, LANES terms per
// valid/ready beat, stopping after a programmed term count, with sticky wrap reporting.
module fibonacci_multi_lane #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANES = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WIDTH-1:0]       seed0,
  input  logic [WIDTH-1:0]       seed1,
  input  logic [CNT_W-1:0]       count,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_mask,
  output logic                   out_last,
  output logic                   done,
  output logic                   overflow
);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e state_q, state_d;

  // Window holds the two terms that start the next beat, plus their wrap taint.
  logic [WIDTH-1:0] win0_q, win1_q;
  logic             taint0_q, taint1_q;
  logic [CNT_W-1:0] rem_q;

  logic             accept, xfer, load;
  logic [WIDTH-1:0] chain [LANES+2];
  logic [LANES+1:0] taint;
  logic [WIDTH:0]   sum;
  logic [CNT_W-1:0] rem_beat;
  logic [LANES-1:0]       beat_mask;
  logic [LANES*WIDTH-1:0] beat_data;
  logic                   beat_last;
  logic                   ovf_hit;

  assign accept = start && (state_q == StIdle);
  assign xfer   = out_valid && out_ready;
  assign load   = (accept && (count != '0)) || (xfer && !out_last);

  // Chain terms: [0..LANES-1] form the beat, [LANES..LANES+1] seed the following one.
  always_comb begin
    chain[0] = accept ? seed0 : win0_q;
    chain[1] = accept ? seed1 : win1_q;
    taint    = '0;
    taint[0] = accept ? 1'b0 : taint0_q;
    taint[1] = accept ? 1'b0 : taint1_q;
    sum      = '0;
    for (int i = 2; i < LANES + 2; i++) begin
      sum      = {1'b0, chain[i-2]} + {1'b0, chain[i-1]};
      chain[i] = sum[WIDTH-1:0];
      taint[i] = sum[WIDTH] | taint[i-1] | taint[i-2];
    end
  end

  always_comb begin
    rem_beat  = accept ? count : (rem_q - CNT_W'(LANES));
    beat_last = (rem_beat <= CNT_W'(LANES));
    beat_mask = '0;
    beat_data = '0;
    ovf_hit   = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      beat_mask[i] = (rem_beat > CNT_W'(i));
      if (beat_mask[i]) begin
        beat_data[i*WIDTH +: WIDTH] = chain[i];
        ovf_hit = ovf_hit | taint[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = (count == '0) ? StFin : StRun;
      StRun:   if (xfer && out_last) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      win0_q    <= '0;
      win1_q    <= '0;
      taint0_q  <= 1'b0;
      taint1_q  <= 1'b0;
      rem_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mask  <= '0;
      out_last  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != StIdle);
      done    <= (state_d == StFin);
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= beat_data;
        out_mask  <= beat_mask;
        out_last  <= beat_last;
        win0_q    <= chain[LANES];
        win1_q    <= chain[LANES+1];
        taint0_q  <= taint[LANES];
        taint1_q  <= taint[LANES+1];
        rem_q     <= rem_beat;
      end else if (xfer) begin
        out_valid <= 1'b0;
        out_data  <= '0;
        out_mask  <= '0;
        out_last  <= 1'b0;
      end
      if (accept) begin
        overflow <= load && ovf_hit;
      end else if (load) begin
        overflow <= overflow | ovf_hit;
      end
    end
  end

endmodule

// File: tb/tb_fibonacci_multi_lane.sv
// Bench for fibonacci_multi_lane: three instances (LANES 1, 2, 3) share stimulus; the one under
// test is selected and compared against a plain-arithmetic Fibonacci model.
module tb_fibonacci_multi_lane;

  logic        clk = 1'b0;
  logic        rst, start, out_ready;
  logic [15:0] seed0, seed1, count;

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int sel    = 2;

  logic        busy1, valid1, last1, done1, ovf1;
  logic [15:0] data1;
  logic [0:0]  mask1;
  logic        busy2, valid2, last2, done2, ovf2;
  logic [31:0] data2;
  logic [1:0]  mask2;
  logic        busy3, valid3, last3, done3, ovf3;
  logic [47:0] data3;
  logic [2:0]  mask3;

  logic        s_busy, s_valid, s_last, s_done, s_ovf;
  logic [3:0]  s_mask;
  logic [63:0] s_data;

  fibonacci_multi_lane #(.WIDTH(16), .LANES(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .start(start), .seed0(seed0), .seed1(seed1), .count(count),
    .busy(busy1), .out_valid(valid1), .out_ready(out_ready), .out_data(data1),
    .out_mask(mask1), .out_last(last1), .done(done1), .overflow(ovf1)
  );
  fibonacci_multi_lane #(.WIDTH(16), .LANES(2), .CNT_W(16)) dut2 (
    .clk(clk), .rst(rst), .start(start), .seed0(seed0), .seed1(seed1), .count(count),
    .busy(busy2), .out_valid(valid2), .out_ready(out_ready), .out_data(data2),
    .out_mask(mask2), .out_last(last2), .done(done2), .overflow(ovf2)
  );
  fibonacci_multi_lane #(.WIDTH(16), .LANES(3), .CNT_W(16)) dut3 (
    .clk(clk), .rst(rst), .start(start), .seed0(seed0), .seed1(seed1), .count(count),
    .busy(busy3), .out_valid(valid3), .out_ready(out_ready), .out_data(data3),
    .out_mask(mask3), .out_last(last3), .done(done3), .overflow(ovf3)
  );

  always_comb begin
    s_busy = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_done = 1'b0; s_ovf = 1'b0;
    s_mask = '0;   s_data = '0;
    case (sel)
      1: begin
        s_busy = busy1; s_valid = valid1; s_last = last1; s_done = done1; s_ovf = ovf1;
        s_mask = {3'b0, mask1}; s_data = {48'b0, data1};
      end
      2: begin
        s_busy = busy2; s_valid = valid2; s_last = last2; s_done = done2; s_ovf = ovf2;
        s_mask = {2'b0, mask2}; s_data = {32'b0, data2};
      end
      default: begin
        s_busy = busy3; s_valid = valid3; s_last = last3; s_done = done3; s_ovf = ovf3;
        s_mask = {1'b0, mask3}; s_data = {16'b0, data3};
      end
    endcase
  end

  // Term k of the sequence, modulo 2^16.
  function automatic logic [15:0] ref_term(input int s0, input int s1, input int k);
    logic [15:0] a, b, t;
    a = 16'(s0);
    b = 16'(s1);
    for (int i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Term k wrapped iff its true (unbounded) value no longer fits in 16 bits.
  function automatic bit ref_wrap(input int s0, input int s1, input int k);
    longint a, b, t;
    a = longint'(s0);
    b = longint'(s1);
    for (int i = 0; i < k; i++) begin
      t = a + b;
      if (t > 64'd1099511627776) t = 64'd1099511627776;
      a = b;
      b = t;
    end
    return a >= 65536;
  endfunction

  function automatic logic [69:0] exp_beat(input int s0, input int s1, input int n,
                                           input int l, input int b);
    logic [63:0] d;
    logic [3:0]  m;
    logic        last;
    int          k;
    d = '0;
    m = '0;
    for (int i = 0; i < l; i++) begin
      k = b * l + i;
      if (k < n) begin
        m[i] = 1'b1;
        d[i*16 +: 16] = ref_term(s0, s1, k);
      end
    end
    last = (b == (n + l - 1) / l - 1);
    return {1'b1, last, m, d};
  endfunction

  function automatic bit exp_ovf(input int s0, input int s1, input int n,
                                 input int l, input int b);
    bit o;
    int hi;
    o  = 1'b0;
    hi = (b * l + l < n) ? b * l + l : n;
    for (int k = 0; k < hi; k++) o = o | ref_wrap(s0, s1, k);
    return o;
  endfunction

  task automatic wait_all_idle();
    int cyc;
    cyc = 0;
    out_ready = 1'b1;
    while ((busy1 | busy2 | busy3) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (busy1 | busy2 | busy3) $display("FAIL idle_timeout busy=%b%b%b want 000", busy1, busy2, busy3);
    else passed++;
  endtask

  // Starts a sequence on all instances and follows the selected one to completion.
  task automatic run_stream(input int s0, input int s1, input int n, input int stall_beat,
                            input int stall_len, input int pct, input bit noise);
    int nb, b, st, cyc, fin_b;
    bit rdy;
    logic [69:0] got, want;
    nb = (n + sel - 1) / sel;
    b = 0; st = 0; cyc = 0;
    seed0 = 16'(s0); seed1 = 16'(s1); count = 16'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (b < nb && cyc < 400) begin
      if (b == stall_beat && st < stall_len) begin
        rdy = 1'b0;
        st++;
      end else begin
        rdy = ($urandom_range(99) >= pct);
      end
      out_ready = rdy;
      if (noise) begin
        start = 1'(($urandom_range(1)));
        seed0 = 16'($urandom);
        seed1 = 16'($urandom);
        count = 16'($urandom_range(8, 1));
      end
      got  = {s_valid, s_last, s_mask, s_data};
      want = exp_beat(s0, s1, n, sel, b);
      total++;
      if (got !== want) $display("FAIL beat L=%0d b=%0d got %h want %h", sel, b, got, want);
      else passed++;
      total++;
      if (s_ovf !== exp_ovf(s0, s1, n, sel, b))
        $display("FAIL overflow L=%0d b=%0d got %b want %b", sel, b, s_ovf,
                 exp_ovf(s0, s1, n, sel, b));
      else passed++;
      if (rdy) b++;
      @(negedge clk);
      cyc++;
    end
    if (b < nb) begin
      total++;
      $display("FAIL stream_timeout L=%0d got %0d beats want %0d", sel, b, nb);
    end
    if (noise) start = 1'b1;
    total++;
    if ({s_busy, s_done, s_valid} !== 3'b110)
      $display("FAIL fin_cycle L=%0d got busy/done/valid=%b want 110", sel,
               {s_busy, s_done, s_valid});
    else passed++;
    @(negedge clk);
    start = 1'b0;
    fin_b = (nb > 0) ? nb - 1 : 0;
    total++;
    if ({s_busy, s_done, s_valid, s_ovf} !== {3'b000, (nb > 0) && exp_ovf(s0, s1, n, sel, fin_b)})
      $display("FAIL after_done L=%0d got busy/done/valid/ovf=%b want %b", sel,
               {s_busy, s_done, s_valid, s_ovf},
               {3'b000, (nb > 0) && exp_ovf(s0, s1, n, sel, fin_b)});
    else passed++;
    wait_all_idle();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    seed0 = '0; seed1 = '0; count = '0;
    @(negedge clk);
    @(negedge clk);
    for (int l = 1; l <= 3; l++) begin
      sel = l;
      #1;
      total++;
      if ({s_busy, s_valid, s_last, s_done, s_ovf, s_mask, s_data} !== 73'd0)
        $display("FAIL reset L=%0d got %h want 0", l,
                 {s_busy, s_valid, s_last, s_done, s_ovf, s_mask, s_data});
      else passed++;
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    sel = 2; run_stream(1, 1, 5, -1, 0, 0, 1'b0);
  endtask

  task automatic test_lucas();
    sel = 3; run_stream(2, 1, 6, -1, 0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    sel = 2; run_stream(1, 1, 6, 1, 3, 0, 1'b0);
  endtask

  task automatic test_overflow();
    sel = 1;
    run_stream(1, 1, 25, -1, 0, 0, 1'b0);
    run_stream(1, 1, 3, -1, 0, 0, 1'b0);
  endtask

  task automatic test_zero_count();
    sel = 2; run_stream(7, 9, 0, -1, 0, 0, 1'b0);
  endtask

  task automatic test_start_while_busy();
    sel = 2; run_stream(1, 1, 6, -1, 0, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [69:0] got, want;
    sel = 2;
    out_ready = 1'b1;
    seed0 = 16'd1; seed1 = 16'd1; count = 16'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    got  = {s_valid, s_last, s_mask, s_data};
    want = exp_beat(1, 1, 10, 2, 1);
    total++;
    if (got !== want) $display("FAIL mid_beat1 got %h want %h", got, want);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({s_busy, s_valid, s_last, s_done, s_ovf, s_mask, s_data} !== 73'd0)
      $display("FAIL mid_reset got %h want 0",
               {s_busy, s_valid, s_last, s_done, s_ovf, s_mask, s_data});
    else passed++;
    run_stream(3, 5, 4, -1, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      sel = $urandom_range(3, 1);
      run_stream(int'($urandom_range(65535)), int'($urandom_range(65535)),
                 int'($urandom_range(20)), int'($urandom_range(4)), int'($urandom_range(3)),
                 30, 1'($urandom_range(1)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lucas();
    test_backpressure();
    test_overflow();
    test_zero_count();
    test_start_while_busy();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fibonacci_multi_lane.md
Name: fibonacci_multi_lane

Overview:
- Parametrised generalised-Fibonacci generator: f(k+2) = f(k) + f(k+1) from two loadable seeds.
- Emits LANES consecutive terms per beat on a valid/ready stream; stops after a programmed number of terms.
- Generalises the single-rate and double-rate Fibonacci generators in width, lane count, seeding and term count.
- Adds backpressure and overflow reporting. Used as a sequence source for datapath and stream tests.

Parameters:
- WIDTH, 16, bit width of every term; all arithmetic is modulo 2^WIDTH.
- LANES, 2, terms per output beat; legal range 1..4.
- CNT_W, 16, width of the term-count input.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request a new sequence; accepted only when busy=0.
- seed0  in  WIDTH  f(0); sampled on the accepted start.
- seed1  in  WIDTH  f(1); sampled on the accepted start.
- count  in  CNT_W  number of terms N to emit; sampled on the accepted start.
- busy  out  1  high from the cycle after start acceptance until done.
- out_valid  out  1  beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  LANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH]; carries f(b*LANES+i) for beat b.
- out_mask  out  LANES  per-lane valid; all ones except on a partial final beat.
- out_last  out  1  marks the final beat.
- done  out  1  single-cycle pulse when the sequence completes.
- overflow  out  1  sticky; an emitted term wrapped modulo 2^WIDTH.

Behaviour:
- Reset: state IDLE. busy, out_valid, out_data, out_mask, out_last, done and overflow are all 0. Internal term registers and counters are cleared.
- States and transitions:
  - IDLE -> RUN on start && !busy with N>0.
  - IDLE -> FIN on start && !busy with N=0.
  - RUN -> FIN on handshake of the beat with out_last=1.
  - FIN -> IDLE after one cycle; done=1 for exactly that cycle.
- Start acceptance:
  - Sample seeds and N; clear overflow.
  - The next cycle has busy=1. In RUN it also has out_valid=1 carrying beat 0 (latency 1).
  - start is ignored while busy, and also in the FIN cycle.
- Beats: beat b carries terms b*LANES .. b*LANES+LANES-1. Number of beats is ceil(N/LANES).
- Final beat:
  - out_last=1.
  - out_mask has the low (N - b*LANES) bits set.
  - Masked-off lanes drive 0.
- Handshake:
  - A beat transfers when out_valid && out_ready.
  - While out_valid && !out_ready, out_data, out_mask and out_last hold stable and the internal state does not advance.
  - After a transfer, the next beat is valid the following cycle. With out_ready tied high, throughput is 1 beat per cycle.
- Registered next-beat computation: the next beat's terms are derived from the last two terms of the current beat in one cycle, using a LANES-deep adder chain. All outputs come directly from registers.
- Arithmetic: each term is the WIDTH-bit sum, carry discarded.
- Overflow flag:
  - overflow is set in the cycle a beat is presented if any unmasked lane's term was produced with a carry-out.
  - This includes carries inherited through earlier wrapped terms.
  - Lookahead terms in masked lanes never set it.
  - Held until the next accepted start or rst.
- Seeds: f(0) and f(1) are emitted verbatim and never set overflow.
- busy drops together with done (in the FIN cycle).
- Reset mid-sequence (rst high in any state): back to IDLE next cycle with all outputs 0. No done pulse and no partial beat.

Test Plan:
- LANES=2, seeds 1,1, N=5, out_ready=1 -> beats (1,1) mask 11, then (2,3) mask 11, then (5,0) mask 01 with last=1. done pulses on the cycle after the last handshake. overflow=0.
- LANES=3, seeds 2,1 (Lucas), N=6 -> (2,1,3), then (4,7,11) with last=1 and mask 111.
- LANES=2, seeds 1,1, N=6, out_ready low for 3 cycles on beat 1 -> (2,3) held stable for all 3 cycles, no beat lost or duplicated; beat 2 = (5,8).
- WIDTH=16, LANES=1, seeds 1,1, N=25 -> term 23 = 46368 with overflow=0; term 24 = 9489 with overflow=1, set while that beat is presented. A new start clears overflow.
- N=0 start -> no out_valid; busy=1 and done=1 for one cycle, then IDLE. A start asserted while busy during a normal run is ignored and the sequence is unaltered.
- rst asserted during beat 1 of an N=10 run -> the next cycle shows all outputs 0 and no done. A fresh start with seeds 3,5 yields (3,5) first.
